// File: rtl/latch_protocol_checker.sv
// Passive protocol checker for a transparent-high latch observed on en/d/q.
// Optional hold-timeout monitor is compiled in with `define LATCH_CHK_TIMEOUT_EN.
`timescale 1ns/1ps
module latch_protocol_checker #(
    parameter int CW       = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic          d,
    input  logic          q,
    output logic          err,
    output logic          err_sticky,
    output logic [CW-1:0] err_cnt,
    output logic [CW-1:0] open_cnt,
    output logic [1:0]    state,
    output logic          timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPEN = 2'd1,
        ST_HOLD = 2'd2,
        ST_BAD  = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = 1;

    state_t        r_state;
    logic          r_exp;
    logic          r_err;
    logic          r_sticky;
    logic [CW-1:0] r_err_cnt;
    logic [CW-1:0] r_open_cnt;
    logic          w_fail;

    // Exactly one check per edge; the opening edge from IDLE/HOLD is a grace cycle.
    always_comb begin
        w_fail = 1'b0;
        case (r_state)
            ST_IDLE: w_fail = !en && q;
            ST_OPEN: w_fail = en ? (q != d) : (q != r_exp);
            ST_HOLD: w_fail = !en && (q != r_exp);
            default: w_fail = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_exp      <= 1'b0;
            r_err      <= 1'b0;
            r_sticky   <= 1'b0;
            r_err_cnt  <= '0;
            r_open_cnt <= '0;
        end else begin
            r_err <= w_fail;
            if (w_fail) begin
                r_sticky <= 1'b1;
                if (r_err_cnt != CNT_MAX)
                    r_err_cnt <= r_err_cnt + CNT_ONE;
            end
            case (r_state)
                ST_IDLE, ST_HOLD: begin
                    if (en) begin
                        r_exp      <= d;
                        r_open_cnt <= r_open_cnt + CNT_ONE;
                        r_state    <= ST_OPEN;
                    end
                end
                ST_OPEN: begin
                    if (en)
                        r_exp <= d;
                    else
                        r_state <= ST_HOLD;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef LATCH_CHK_TIMEOUT_EN
    localparam int          HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = 1;

    logic [HW-1:0] r_hold_cnt;
    logic          r_timeout;
    logic [HW-1:0] w_hold_nxt;

    // Counter parks at the limit so it cannot wrap back under it.
    assign w_hold_nxt = (r_hold_cnt == HOLD_LIM) ? r_hold_cnt : r_hold_cnt + HOLD_ONE;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (r_state == ST_HOLD && !en) begin
                r_hold_cnt <= w_hold_nxt;
                if (w_hold_nxt == HOLD_LIM)
                    r_timeout <= 1'b1;
            end else if (en) begin
                r_hold_cnt <= '0;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign err        = r_err;
    assign err_sticky = r_sticky;
    assign err_cnt    = r_err_cnt;
    assign open_cnt   = r_open_cnt;
    assign state      = r_state;

endmodule

// File: tb/tb_latch_protocol_checker.sv
// Directed bench for latch_protocol_checker: vector table plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_latch_protocol_checker;

`ifdef LATCH_CHK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn, en, d, q;
    logic       q_drv = 1'b0;
    logic       q_lat = 1'b0;
    logic       use_lat = 1'b1;
    logic       err, stk, tmo;
    logic [7:0] ec, oc;
    logic [1:0] st;
    logic       err2, stk2, tmo2;
    logic [1:0] ec2, oc2, st2;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    bit mon_en = 1'b0;

    latch_protocol_checker #(.CW(8), .MAX_HOLD(4)) dut (
        .clk(clk), .rstn(rstn), .en(en), .d(d), .q(q),
        .err(err), .err_sticky(stk), .err_cnt(ec), .open_cnt(oc),
        .state(st), .timeout(tmo)
    );

    latch_protocol_checker #(.CW(2)) dut2 (
        .clk(clk), .rstn(rstn), .en(en), .d(d), .q(q),
        .err(err2), .err_sticky(stk2), .err_cnt(ec2), .open_cnt(oc2),
        .state(st2), .timeout(tmo2)
    );

    initial begin
        #2;
        forever #5 clk = ~clk;
    end

    always @(en or d) if (en) q_lat = d;
    assign q = use_lat ? q_lat : q_drv;

    always @(negedge clk) if (mon_en && err) err_seen++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       en, d, q;
        logic       err, stk;
        logic [1:0] st;
        logic [7:0] ec, oc;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic dd, input logic qq);
        en = e;
        d = dd;
        q_drv = qq;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0;
        d = 1'b0;
        q_drv = 1'b0;
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'd1, 8'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'd1, 8'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'd1, 8'd1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 8'd1, 8'd1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 8'd1, 8'd1};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 8'd2, 8'd1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 8'd2, 8'd1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 8'd2, 8'd1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 8'd2, 8'd1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 8'd3, 8'd1};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 8'd3, 8'd2};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 8'd3, 8'd2};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 8'd4, 8'd2};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 8'd4, 8'd2};

        // Well-behaved latch driven on a fixed timeline.
        rstn = 1'b0;
        en = 1'b0;
        d = 1'b0;
        use_lat = 1'b1;
        #10;
        chk("rst_state", st, 0);
        chk("rst_err", err, 0);
        chk("rst_sticky", stk, 0);
        chk("rst_err_cnt", ec, 0);
        chk("rst_open_cnt", oc, 0);
        chk("rst_timeout", tmo, 0);
        #15;
        rstn = 1'b1;
        mon_en = 1'b1;
        #25;
        for (int i = 0; i < 5; i++) begin
            en = ~en;
            if (i >= 2) d = ~d;
            #50;
        end
        d = ~d;
        #50;
        d = ~d;
        #20;
        mon_en = 1'b0;
        chk("good_err_seen", err_seen, 0);
        chk("good_err_cnt", ec, 0);
        chk("good_open_cnt", oc, 3);
        chk("good_sticky", stk, 0);
        chk("good_state", st, 1);

        use_lat = 1'b0;
        @(posedge clk);
        #1;

        // Table of single-edge vectors from a clean reset.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].en, tbl[i].d, tbl[i].q);
            chk($sformatf("vec%0d err", i), err, tbl[i].err);
            chk($sformatf("vec%0d sticky", i), stk, tbl[i].stk);
            chk($sformatf("vec%0d state", i), st, tbl[i].st);
            chk($sformatf("vec%0d err_cnt", i), ec, tbl[i].ec);
            chk($sformatf("vec%0d open_cnt", i), oc, tbl[i].oc);
        end

        // Stuck-low q while transparent: grace edge, then three failures.
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        chk("stuck_grace_err", err, 0);
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 1'b1, 1'b0);
            chk($sformatf("stuck%0d err", k), err, 1);
            chk($sformatf("stuck%0d err_cnt", k), ec, k);
        end
        chk("stuck_sticky", stk, 1);
        step(1'b1, 1'b1, 1'b1);
        chk("stuck_recover_err", err, 0);
        chk("stuck_final_cnt", ec, 3);

        // q leaks through in HOLD; expected value must stay at the latched 1.
        do_reset();
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("leak_enter_hold", st, 2);
        chk("leak_enter_err", err, 0);
        step(1'b0, 1'b0, 1'b0);
        chk("leak_err", err, 1);
        chk("leak_state", st, 2);
        step(1'b0, 1'b0, 1'b1);
        chk("leak_exp_kept", err, 0);
        chk("leak_err_cnt", ec, 1);

        // Saturation of err_cnt and wrap of open_cnt on the CW=2 instance.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b0, 1'b1);
            chk($sformatf("sat%0d err2", k), err2, 1);
            chk($sformatf("sat%0d err_cnt2", k), ec2, (k > 3) ? 3 : k);
        end
        chk("sat_err_cnt_wide", ec, 5);
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 1'b0, 1'b0);
            chk($sformatf("wrap%0d open_cnt2", k), oc2, k % 4);
            step(1'b0, 1'b0, 1'b0);
        end
        chk("wrap_open_cnt_wide", oc, 5);
        chk("wrap_err_cnt2_held", ec2, 3);

        // Reset pulse mid-window clears everything at once.
        do_reset();
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("mid_pre_state", st, 1);
        chk("mid_pre_sticky", stk, 1);
        en = 1'b0;
        d = 1'b0;
        q_drv = 1'b1;
        rstn = 1'b0;
        #1;
        chk("mid_rst_state", st, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_sticky", stk, 0);
        chk("mid_rst_err_cnt", ec, 0);
        chk("mid_rst_open_cnt", oc, 0);
        chk("mid_rst_timeout", tmo, 0);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_post_err", err, 1);
        chk("mid_post_state", st, 0);
        chk("mid_post_err_cnt", ec, 1);

        // Long HOLD: timeout only when compiled in, never an error.
        do_reset();
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b1, 1'b1);
            chk($sformatf("hold%0d timeout", k), tmo, (TO_EN && k == 4) ? 1 : 0);
        end
        step(1'b0, 1'b1, 1'b1);
        chk("hold_timeout_sticky", tmo, TO_EN ? 1 : 0);
        chk("hold_err", err, 0);
        chk("hold_err_cnt", ec, 0);
        chk("hold_sticky", stk, 0);
        chk("hold_timeout_cw2", tmo2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
